// File: rtl/fp32_pkg.sv
// Shared IEEE-754 binary32 field geometry and the unpacked-operand payload.
package fp32_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MAN_W    = 33;
  localparam int unsigned BIAS     = 127;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_fields_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits one binary32 word into sign, biased exponent and zero-extended
// significand with the hidden bit restored (hidden = 0 for zero/denormals).
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [FP_W-1:0] op,
  output fp32_fields_t    fields_c
);

  logic hidden_c;

  always_comb begin
    fields_c      = '0;
    hidden_c      = |op[EXP_MSB:EXP_LSB];
    fields_c.sign = op[SIGN_BIT];
    fields_c.exp  = op[EXP_MSB:EXP_LSB];
    // Inf/NaN keep hidden = 1 and their payload; classification is downstream.
    fields_c.man  = MAN_W'({hidden_c, op[FRAC_W-1:0]});
  end

endmodule

// File: rtl/fpm_operand_unpack.sv
// Multiplier front end: capture operands, unpack them, register raw words
// and fields together. Fixed 2-cycle latency, one pair per cycle, no stall.
module fpm_operand_unpack
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [FP_W-1:0]  a,
  input  logic [FP_W-1:0]  b,
  output logic [FP_W-1:0]  a_q,
  output logic [FP_W-1:0]  b_q,
  output logic [MAN_W-1:0] man_a,
  output logic [MAN_W-1:0] man_b,
  output logic [EXP_W-1:0] exp_a,
  output logic [EXP_W-1:0] exp_b,
  output logic             sign_a,
  output logic             sign_b
);

  logic [FP_W-1:0] a1;
  logic [FP_W-1:0] b1;
  fp32_fields_t    fa_c;
  fp32_fields_t    fb_c;

  fp32_unpack u_unpack_a (
    .op       (a1),
    .fields_c (fa_c)
  );

  fp32_unpack u_unpack_b (
    .op       (b1),
    .fields_c (fb_c)
  );

  // Stage 1 captures raw operands; stage 2 registers raw words plus fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1     <= '0;
      b1     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      man_a  <= '0;
      man_b  <= '0;
      exp_a  <= '0;
      exp_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      a1     <= a;
      b1     <= b;
      a_q    <= a1;
      b_q    <= b1;
      man_a  <= fa_c.man;
      man_b  <= fb_c.man;
      exp_a  <= fa_c.exp;
      exp_b  <= fb_c.exp;
      sign_a <= fa_c.sign;
      sign_b <= fb_c.sign;
    end
  end

endmodule

// File: tb/tb_fpm_operand_unpack.sv
// Scoreboard bench for fpm_operand_unpack: expectations are queued at drive
// time and popped two cycles later when the matching output is due.
module tb_fpm_operand_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] a_q, b_q;
  logic [32:0] man_a, man_b;
  logic [7:0]  exp_a, exp_b;
  logic        sign_a, sign_b;

  typedef struct packed {
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [32:0] man_a;
    logic [32:0] man_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        sign_a;
    logic        sign_b;
  } out_t;

  out_t sb_q[$];
  out_t expd;
  bit   have;
  int   checks = 0;
  int   errors = 0;

  fpm_operand_unpack dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .a_q    (a_q),
    .b_q    (b_q),
    .man_a  (man_a),
    .man_b  (man_b),
    .exp_a  (exp_a),
    .exp_b  (exp_b),
    .sign_a (sign_a),
    .sign_b (sign_b)
  );

  always #5 clk = ~clk;

  function automatic out_t model(input logic [31:0] ra, input logic [31:0] rb);
    out_t m;
    m.a_q    = ra;
    m.b_q    = rb;
    m.exp_a  = ra[30:23];
    m.exp_b  = rb[30:23];
    m.man_a  = {9'b0, (ra[30:23] != 8'h00), ra[22:0]};
    m.man_b  = {9'b0, (rb[30:23] != 8'h00), rb[22:0]};
    m.sign_a = ra[31];
    m.sign_b = rb[31];
    return m;
  endfunction

  function automatic out_t observed();
    out_t o;
    o.a_q    = a_q;
    o.b_q    = b_q;
    o.man_a  = man_a;
    o.man_b  = man_b;
    o.exp_a  = exp_a;
    o.exp_b  = exp_b;
    o.sign_a = sign_a;
    o.sign_b = sign_b;
    return o;
  endfunction

  // One cycle: pop the expectation due now, then drive and queue a new pair.
  task automatic step(input logic [31:0] na, input logic [31:0] nb);
    @(negedge clk);
    have = 1'b0;
    if (sb_q.size() >= 2) begin
      expd = sb_q.pop_front();
      have = 1'b1;
    end
    a = na;
    b = nb;
    sb_q.push_back(model(na, nb));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a   = 32'h4000_0000;
    b   = 32'h4080_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== out_t'(0)) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want 0", i, observed());
      end
    end
    rst = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_basic();
    logic [31:0] va[4] = '{32'h4000_0000, 32'h42FA_4000, 32'h0, 32'h0};
    logic [31:0] vb[4] = '{32'h4080_0000, 32'h4141_0000, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      step(va[i], vb[i]);
      if (have) begin
        checks++;
        if (observed() !== expd) begin
          errors++;
          $display("FAIL basic[%0d]: got %h want %h", i, observed(), expd);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va[6] = '{32'h7F80_0000, 32'h7F80_0007, 32'h0000_0000,
                           32'h0000_0001, 32'h8000_0000, 32'h3F80_0000};
    logic [31:0] vb[6] = '{32'hFF80_0000, 32'h0040_0000, 32'h7FC0_1234,
                           32'hC000_0000, 32'h807F_FFFF, 32'hC000_0000};
    for (int i = 0; i < 6; i++) begin
      step(va[i], vb[i]);
      if (have) begin
        checks++;
        if (observed() !== expd) begin
          errors++;
          $display("FAIL special[%0d]: got %h want %h", i, observed(), expd);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(32'h0, 32'h0);
      checks++;
      if (observed() !== expd) begin
        errors++;
        $display("FAIL special_drain[%0d]: got %h want %h", i, observed(), expd);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      step((i < 4) ? $urandom() : 32'h0, (i < 4) ? $urandom() : 32'h0);
      checks++;
      if (!have || observed() !== expd) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, observed(), expd);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(32'hC2FA_4000 + 32'(i), 32'h4141_0000);
    checks++;
    if (a_q === 32'h0) begin
      errors++;
      $display("FAIL mid_reset_pre: got a_q %h want nonzero", a_q);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (observed() !== out_t'(0)) begin
      errors++;
      $display("FAIL mid_reset_async: got %h want 0", observed());
    end
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step((i < 3) ? (32'h3F80_0000 + 32'(i)) : 32'h0, 32'hBF00_0000);
      if (have) begin
        checks++;
        if (observed() !== expd) begin
          errors++;
          $display("FAIL mid_reset_resume[%0d]: got %h want %h", i, observed(), expd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
